// File: rtl/traffic_pkg.sv
// traffic_pkg: mode encodings, emergency FSM states and default widths shared by the request front end
package traffic_pkg;
    localparam logic [1:0] MODE_EMG   = 2'd0;
    localparam logic [1:0] MODE_PED   = 2'd1;
    localparam logic [1:0] MODE_NIGHT = 2'd2;
    localparam logic [1:0] MODE_DAY   = 2'd3;
    localparam int DEF_LANES   = 8;
    localparam int DEF_CORNERS = 8;
    typedef enum logic [1:0] {E_IDLE, E_GRANT, E_GAP} emg_state_t;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: per-bit saturating debounce with a one-cycle rising-edge pulse of the debounced bit
module input_debouncer #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_deb,
    output logic [WIDTH-1:0] o_rise
);
    localparam int CW = $clog2(DEBOUNCE) + 1;
    logic [WIDTH-1:0] r_deb_q;
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic [CW-1:0] r_cnt;
        always_ff @(posedge clk or posedge rst)
            if (rst) r_cnt <= '0;
            else     r_cnt <= !i_raw[g] ? '0 : (r_cnt == CW'(DEBOUNCE) ? r_cnt : r_cnt + 1'b1);
        assign o_deb[g] = r_cnt == CW'(DEBOUNCE);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_deb_q <= '0;
        else     r_deb_q <= o_deb;
    assign o_rise = o_deb & ~r_deb_q;
endmodule

// File: rtl/traffic_request_encoder.sv
// traffic_request_encoder: debounces detectors/buttons, round-robin grants emergencies with hold
// limits, and latches pedestrian requests until the controller has served them
module traffic_request_encoder
    import traffic_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int CORNERS  = DEF_CORNERS,
    parameter int DEBOUNCE = 3,
    parameter int EMG_HOLD = 16,
    parameter int EMG_MAX  = 64,
    parameter int PED_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   emgDetect,
    input  logic [CORNERS-1:0] pedButton,
    input  logic [1:0]         trafficMode,
    output logic               emgSignal,
    output logic [LANES-1:0]   emgLane,
    output logic               pedSignal,
    output logic [CORNERS-1:0] pedLatched
);
    localparam int PW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int HW = $clog2(EMG_MAX) + 1;
    localparam int CW = $clog2(PED_HOLD) + 1;

    logic [LANES-1:0]   w_emg_deb;
    logic [CORNERS-1:0] w_ped_rise;
    logic [PW-1:0]      w_pick;
    logic               w_release;
    logic               w_ped_active;
    logic               w_ped_served;

    emg_state_t         r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_idx;
    logic [HW-1:0]      r_hold;
    logic               r_emg_signal;
    logic [LANES-1:0]   r_emg_lane;
    logic [CORNERS-1:0] r_ped_latched;
    logic [CW-1:0]      r_ped_cnt;
    logic               r_ped_signal;

    input_debouncer #(.WIDTH(LANES), .DEBOUNCE(DEBOUNCE)) u_emg_deb (
        .clk(clk), .rst(rst), .i_raw(emgDetect), .o_deb(w_emg_deb), .o_rise()
    );
    input_debouncer #(.WIDTH(CORNERS), .DEBOUNCE(DEBOUNCE)) u_ped_deb (
        .clk(clk), .rst(rst), .i_raw(pedButton), .o_deb(), .o_rise(w_ped_rise)
    );

    // walking downward leaves the nearest set lane at or above r_ptr as the final pick
    always_comb begin
        w_pick = '0;
        for (int k = LANES - 1; k >= 0; k--)
            if (w_emg_deb[(int'(r_ptr) + k) % LANES]) w_pick = PW'((int'(r_ptr) + k) % LANES);
    end

    assign w_release = (r_hold >= HW'(EMG_HOLD - 1) && !w_emg_deb[r_idx]) || r_hold == HW'(EMG_MAX - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state      <= E_IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_hold       <= '0;
            r_emg_signal <= 1'b0;
            r_emg_lane   <= '0;
        end else begin
            case (r_state)
                E_IDLE:
                    if (|w_emg_deb) begin
                        r_state      <= E_GRANT;
                        r_idx        <= w_pick;
                        r_emg_lane   <= LANES'(1) << w_pick;
                        r_emg_signal <= 1'b1;
                        r_hold       <= '0;
                    end
                E_GRANT:
                    if (w_release) begin
                        r_state      <= E_GAP;
                        r_emg_signal <= 1'b0;
                        r_emg_lane   <= '0;
                        r_ptr        <= r_idx == PW'(LANES - 1) ? '0 : r_idx + 1'b1;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                default: r_state <= E_IDLE;
            endcase
        end

    // service only counts while the controller is in pedestrian mode with something pending
    assign w_ped_active = trafficMode == MODE_PED && |r_ped_latched;
    assign w_ped_served = w_ped_active && r_ped_cnt == CW'(PED_HOLD - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_ped_latched <= '0;
            r_ped_cnt     <= '0;
            r_ped_signal  <= 1'b0;
        end else begin
            r_ped_latched <= w_ped_served ? w_ped_rise : r_ped_latched | w_ped_rise;
            r_ped_cnt     <= w_ped_active && !w_ped_served ? r_ped_cnt + 1'b1 : '0;
            r_ped_signal  <= |r_ped_latched && !r_emg_signal;
        end

    assign emgSignal  = r_emg_signal;
    assign emgLane    = r_emg_lane;
    assign pedSignal  = r_ped_signal;
    assign pedLatched = r_ped_latched;
endmodule
